// File: rtl/uart_wb_bridge.sv
// UART byte-stream to wishbone command bridge: assembles 'W'/'R' frames from RX bytes,
// issues one wishbone transaction per frame and streams the status/read data back on TX.
module uart_wb_bridge #(
    parameter int ADDR_BITS  = 32,
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    i_controller_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [ADDR_BITS-1:0]    o_wb_addr,
    output logic [8*DATA_BYTES-1:0] o_wb_data,
    output logic [DATA_BYTES-1:0]   o_wb_sel,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_ack,
    input  logic [8*DATA_BYTES-1:0] i_wb_data,
    output logic                    o_busy,
    output logic                    o_err,
    output logic                    o_drop
);

    localparam int AW_SR     = 8 * ADDR_BYTES;
    localparam int DW        = 8 * DATA_BYTES;
    localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES) + 1;
    localparam int TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_TMO = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_REQ      = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    we_q, we_d;
    logic                    tmo_q, tmo_d;
    logic [AW_SR-1:0]        addr_sr_q, addr_sr_d;
    logic [DW-1:0]           wb_data_q, wb_data_d;
    logic [DW-1:0]           rd_data_q, rd_data_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic [DATA_BYTES-1:0]   sel_q, sel_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    drop_q, drop_d;
    logic                    enter_req_s, ack_done_s, abort_s;
    logic [CNT_W-1:0]        tx_idx_s, resp_last_s;
    logic [7:0]              tx_byte_s;

    function automatic logic [7:0] pick_byte(input logic [DW-1:0] d, input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < DATA_BYTES; k++) begin
            b = (idx == CNT_W'(k)) ? d[8*k +: 8] : b;
        end
        return b;
    endfunction

    // Next-state, frame assembly, bus handshake and response sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        we_d        = we_q;
        tmo_d       = tmo_q;
        addr_sr_d   = addr_sr_q;
        wb_data_d   = wb_data_q;
        rd_data_d   = rd_data_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        sel_d       = sel_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        err_d       = 1'b0;
        drop_d      = 1'b0;
        enter_req_s = 1'b0;
        ack_done_s  = 1'b0;
        abort_s     = 1'b0;
        // While a byte is on offer, the next byte to present is one past the current index.
        tx_idx_s    = tx_valid_q ? cnt_q + 1'b1 : cnt_q;
        tx_byte_s   = tmo_q ? RSP_TMO : (we_q ? RSP_OK : pick_byte(rd_data_q, tx_idx_s));
        resp_last_s = (tmo_q | we_q) ? {CNT_W{1'b0}} : DATA_LAST;

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == CMD_WR || i_rx_data == CMD_RD)) begin
                    state_d = S_ADDR;
                    we_d    = (i_rx_data == CMD_WR);
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    drop_d = i_rx_valid;
                end
            end
            S_ADDR: begin
                if (i_rx_valid) begin
                    addr_sr_d = AW_SR'({addr_sr_q, i_rx_data});
                    if (cnt_q != ADDR_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (we_q) begin
                        state_d = S_DATA;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        enter_req_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    for (int k = 0; k < DATA_BYTES; k++) begin
                        wb_data_d[8*k +: 8] = (cnt_q == CNT_W'(k)) ? i_rx_data : wb_data_q[8*k +: 8];
                    end
                    cnt_d       = cnt_q + 1'b1;
                    enter_req_s = (cnt_q == DATA_LAST);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_REQ: begin
                drop_d = i_rx_valid;
                // An ack only counts when it arrives with the accepting (unstalled) cycle.
                if (!i_wb_stall && i_wb_ack) begin
                    ack_done_s = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    stb_d     = i_wb_stall;
                    state_d   = i_wb_stall ? S_REQ : S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                drop_d = i_rx_valid;
                if (i_wb_ack) begin
                    ack_done_s = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                drop_d = i_rx_valid;
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = tx_byte_s;
                end else if (i_tx_ready && cnt_q == resp_last_s) begin
                    tx_valid_d = 1'b0;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = S_IDLE;
                end else if (i_tx_ready) begin
                    cnt_d     = tx_idx_s;
                    tx_data_d = tx_byte_s;
                end else begin
                    tx_data_d = tx_data_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                cyc_d      = 1'b0;
                stb_d      = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase

        if (enter_req_s) begin
            state_d   = S_REQ;
            cyc_d     = 1'b1;
            stb_d     = 1'b1;
            sel_d     = {DATA_BYTES{1'b1}};
            tmo_cnt_d = {TMO_W{1'b0}};
            tmo_d     = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
        end else if (ack_done_s || abort_s) begin
            state_d   = S_RESP;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            sel_d     = {DATA_BYTES{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            tmo_d     = abort_s;
            err_d     = abort_s;
            rd_data_d = (ack_done_s && !we_q) ? i_wb_data : rd_data_q;
        end else begin
            sel_d = sel_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge i_controller_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            tmo_cnt_q  <= {TMO_W{1'b0}};
            we_q       <= 1'b0;
            tmo_q      <= 1'b0;
            addr_sr_q  <= {AW_SR{1'b0}};
            wb_data_q  <= {DW{1'b0}};
            rd_data_q  <= {DW{1'b0}};
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            sel_q      <= {DATA_BYTES{1'b0}};
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            we_q       <= we_d;
            tmo_q      <= tmo_d;
            addr_sr_q  <= addr_sr_d;
            wb_data_q  <= wb_data_d;
            rd_data_q  <= rd_data_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            sel_q      <= sel_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_sr_q[ADDR_BITS-1:0];
    assign o_wb_data  = wb_data_q;
    assign o_wb_sel   = sel_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed and randomized command frames for uart_wb_bridge, checked against a
// frame-level reference model of the bus request and the TX response stream.
module tb_uart_wb_bridge;

    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;
    logic         o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0]  o_wb_addr;
    logic [127:0] o_wb_data;
    logic [15:0]  o_wb_sel;
    logic         i_wb_stall, i_wb_ack;
    logic [127:0] i_wb_data;
    logic         o_busy, o_err, o_drop;

    int errors = 0;
    int checks = 0;

    uart_wb_bridge #(.ADDR_BITS(32), .ADDR_BYTES(4), .DATA_BYTES(16), .TIMEOUT(TMO)) dut (
        .i_controller_clk(clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
        .o_busy(o_busy), .o_err(o_err), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        step();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference response: one status byte for writes/timeouts, else read data LSB byte first.
    function automatic logic [7:0] exp_byte(input bit we, input bit tmo, input logic [127:0] rd, input int i);
        logic [127:0] t;
        if (tmo) return 8'h54;
        if (we) return 8'h4B;
        t = rd >> (8 * i);
        return t[7:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_cyc"}, o_wb_cyc, 1'b0);
        chk1({tag, "_stb"}, o_wb_stb, 1'b0);
        chk1({tag, "_we"}, o_wb_we, 1'b0);
        chk({tag, "_addr"}, 128'(o_wb_addr), 128'h0);
        chk({tag, "_data"}, o_wb_data, 128'h0);
        chk({tag, "_sel"}, 128'(o_wb_sel), 128'h0);
        chk1({tag, "_txv"}, o_tx_valid, 1'b0);
        chk({tag, "_txd"}, 128'(o_tx_data), 128'h0);
        chk1({tag, "_busy"}, o_busy, 1'b0);
        chk1({tag, "_err"}, o_err, 1'b0);
        chk1({tag, "_drop"}, o_drop, 1'b0);
    endtask

    // One full command: frame, bus request (stall/ack/timeout), response collection.
    // ack_dly < 0 means the bus never acks; rmode 0=ready always, 1=toggle, 2=random.
    task automatic run_cmd(input bit we, input logic [31:0] addr, input logic [127:0] wdata,
                           input int stall_n, input int ack_dly, input logic [127:0] rdata,
                           input int rmode, input bit noise);
        logic [7:0] fr[$];
        int n, got_n, exp_n, guard;
        bit tmo, rdy, tog;
        tmo = (ack_dly < 0);
        fr.push_back(we ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) fr.push_back(addr[8*i +: 8]);
        if (we) for (int k = 0; k < 16; k++) fr.push_back(wdata[8*k +: 8]);
        chk1("idle_busy", o_busy, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i]);
            if (i != fr.size() - 1) begin
                chk1("frame_cyc", o_wb_cyc, 1'b0);
                chk1("frame_drop", o_drop, 1'b0);
                chk1("frame_busy", o_busy, 1'b1);
                repeat ($urandom_range(0, 2)) step();
            end
        end
        chk1("req_cyc", o_wb_cyc, 1'b1);
        chk1("req_stb", o_wb_stb, 1'b1);
        chk1("req_we", o_wb_we, we);
        chk("req_addr", 128'(o_wb_addr), 128'(addr));
        chk("req_sel", 128'(o_wb_sel), 128'hFFFF);
        if (we) chk("req_data", o_wb_data, wdata);

        for (int s = 0; s < stall_n; s++) begin
            i_wb_stall = 1'b1;
            i_wb_ack   = (s == 2);
            i_wb_data  = rnd128();
            step();
            i_wb_ack = 1'b0;
            chk1("stall_stb", o_wb_stb, 1'b1);
            chk1("stall_cyc", o_wb_cyc, 1'b1);
            chk("stall_addr", 128'(o_wb_addr), 128'(addr));
            if (we) chk("stall_data", o_wb_data, wdata);
        end
        i_wb_stall = 1'b0;
        i_wb_ack   = (ack_dly == 0);
        i_wb_data  = (ack_dly == 0) ? rdata : rnd128();
        step();
        i_wb_ack  = 1'b0;
        i_wb_data = rnd128();
        chk1("accept_stb", o_wb_stb, 1'b0);

        if (tmo) begin
            n = stall_n + 1;
            guard = 0;
            while (o_wb_cyc === 1'b1 && guard < 100) begin
                n++;
                guard++;
                step();
            end
            chk("timeout_cycles", 128'(n), 128'(TMO));
            chk1("timeout_err", o_err, 1'b1);
        end else if (ack_dly == 0) begin
            chk1("ack_at_accept_cyc", o_wb_cyc, 1'b0);
        end else begin
            chk1("wait_cyc", o_wb_cyc, 1'b1);
            for (int d = 0; d < ack_dly; d++) begin
                i_rx_valid = noise && (d == 0);
                i_wb_ack   = (d == ack_dly - 1);
                i_wb_data  = (d == ack_dly - 1) ? rdata : rnd128();
                step();
                i_rx_valid = 1'b0;
                i_wb_ack   = 1'b0;
                i_wb_data  = rnd128();
                if (noise && d == 0) chk1("wait_drop", o_drop, 1'b1);
                if (d != ack_dly - 1) chk1("wait_stb", o_wb_stb, 1'b0);
            end
            chk1("ack_cyc", o_wb_cyc, 1'b0);
        end
        chk1("resp0_txv", o_tx_valid, 1'b0);
        chk1("resp0_busy", o_busy, 1'b1);
        if (!tmo) chk1("resp0_err", o_err, 1'b0);
        step();
        chk1("resp1_txv", o_tx_valid, 1'b1);
        chk1("resp1_err", o_err, 1'b0);

        exp_n = (we || tmo) ? 1 : 16;
        got_n = 0;
        guard = 0;
        tog   = 1'b0;
        while (got_n < exp_n && guard < 200) begin
            case (rmode)
                0: rdy = 1'b1;
                1: begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_tx_ready = rdy;
            chk1("tx_valid_held", o_tx_valid, 1'b1);
            if (rdy) begin
                chk("tx_byte", 128'(o_tx_data), 128'(exp_byte(we, tmo, rdata, got_n)));
                got_n++;
            end
            step();
            guard++;
        end
        i_tx_ready = 1'b0;
        chk("tx_count", 128'(got_n), 128'(exp_n));
        chk1("tx_done_valid", o_tx_valid, 1'b0);
        chk1("tx_done_busy", o_busy, 1'b0);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_data  = 128'h0;
        repeat (3) step();
        chk_all_zero("reset");
        @(negedge clk);
        i_rst = 1'b0;
        step();

        // Write with fixed data, ack three cycles after accept.
        run_cmd(1'b1, 32'h5, 128'h0F0E0D0C0B0A09080706050403020100, 0, 3, 128'h0, 0, 1'b0);
        // Read, transmitter ready every other cycle.
        run_cmd(1'b0, 32'h5, 128'h0, 0, 2, 128'h0F0E0D0C0B0A09080706050403020100, 1, 1'b0);
        // Seven stalled cycles, ack coincident with accept.
        run_cmd(1'b1, $urandom, rnd128(), 7, 0, 128'h0, 2, 1'b0);
        // Timeout, then a normal read.
        run_cmd(1'b0, $urandom, 128'h0, 0, -1, 128'h0, 0, 1'b0);
        run_cmd(1'b0, $urandom, 128'h0, 0, 1, rnd128(), 2, 1'b0);

        // Discarded bytes in IDLE, then a read with a byte dropped during WAIT_ACK.
        send_byte(8'h41);
        chk1("idle_drop_a", o_drop, 1'b1);
        chk1("idle_drop_a_cyc", o_wb_cyc, 1'b0);
        chk1("idle_drop_a_busy", o_busy, 1'b0);
        send_byte(8'h00);
        chk1("idle_drop_b", o_drop, 1'b1);
        step();
        chk1("idle_drop_end", o_drop, 1'b0);
        chk1("idle_drop_b_cyc", o_wb_cyc, 1'b0);
        run_cmd(1'b0, 32'hA5A5_0004, 128'h0, 0, 3, rnd128(), 0, 1'b1);

        // Reset mid-DATA.
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        chk1("middata_busy", o_busy, 1'b1);
        #2 i_rst = 1'b1;
        #1 chk_all_zero("rst_data");
        step();
        @(negedge clk);
        i_rst = 1'b0;
        step();
        // Reset mid-WAIT_ACK, then a stray ack.
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        step();
        chk1("midwait_cyc", o_wb_cyc, 1'b1);
        #2 i_rst = 1'b1;
        #1 chk_all_zero("rst_wait");
        step();
        @(negedge clk);
        i_rst = 1'b0;
        step();
        i_wb_ack = 1'b1;
        step();
        i_wb_ack = 1'b0;
        chk1("stray_cyc", o_wb_cyc, 1'b0);
        chk1("stray_busy", o_busy, 1'b0);
        step();
        chk1("stray_txv", o_tx_valid, 1'b0);
        run_cmd(1'b1, $urandom, rnd128(), 1, 2, 128'h0, 0, 1'b0);

        // Randomized commands.
        for (int r = 0; r < 8; r++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom, rnd128(), $urandom_range(0, 3),
                    $urandom_range(0, 4), rnd128(), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
